// File: rtl/keypad_if.sv
`default_nettype none
// ============================================================================
// keypad_if : keypad scan lines and decoded-value outputs of keypad_entry
// Revision  : 1.0
// ============================================================================
interface keypad_if;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [15:0] num;
  logic [3:0]  key_code;
  logic        key_valid;

  modport master (
    output cols,
    output num,
    output key_code,
    output key_valid,
    input  rows
  );

  modport slave (
    input  cols,
    input  num,
    input  key_code,
    input  key_valid,
    output rows
  );
endinterface
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// keypad_entry : 4x4 matrix keypad scanner, debouncer and decimal accumulator
// Revision     : 1.0
// ============================================================================
module keypad_entry #(
  parameter int SCAN_DIV = 25000,
  parameter int DEBOUNCE = 4
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int                   DIV_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int                   MATCH_W   = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [MATCH_W-1:0]   MATCH_MAX = MATCH_W'(DEBOUNCE);
  localparam logic [MATCH_W-1:0]   MATCH_ONE = MATCH_W'(1);
  // Nibble i holds the code of frame bit i (bit 4c+r = column c, row r).
  localparam logic [63:0]          KEY_MAP   = 64'hDCBA_E963_F852_0741;
  localparam logic [3:0]           KEY_B     = 4'hB;
  localparam logic [3:0]           KEY_C     = 4'hC;
  localparam logic [3:0]           KEY_9     = 4'h9;

  typedef enum logic [0:0] {
    RELEASED = 1'b0,
    HELD     = 1'b1
  } state_t;

  logic [3:0]         rows_meta;
  logic [3:0]         rows_sync;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         col_idx;
  logic [15:0]        frame;
  logic [15:0]        prev_frame;
  logic [15:0]        frame_new;
  logic [MATCH_W-1:0] match_cnt;
  logic [MATCH_W-1:0] match_next;
  logic               sample;
  logic               frame_done;
  logic               stable;
  logic               single_key;
  logic [3:0]         code;
  logic [15:0]        num_digit;
  state_t             state;
  state_t             state_next;
  logic               fire;
  logic [15:0]        num_q;
  logic [3:0]         code_q;
  logic               valid_q;

  assign sample     = (div_cnt == DIV_LAST);
  assign frame_done = sample && (col_idx == 2'd3);

  // Frame as it will look once the current column's rows are folded in.
  always_comb begin
    frame_new = frame;
    if (sample) begin
      frame_new[{col_idx, 2'b00} +: 4] = ~rows_sync;
    end
  end

  always_comb begin
    match_next = MATCH_ONE;
    if (frame_new == prev_frame) begin
      match_next = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MATCH_ONE;
    end
  end

  assign stable     = frame_done && (match_next == MATCH_MAX);
  assign single_key = (frame_new != 16'd0) &&
                      ((frame_new & (frame_new - 16'd1)) == 16'd0);

  always_comb begin
    code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_new[i]) begin
        code = KEY_MAP[4*i +: 4];
      end
    end
  end

  // Shift in a digit keeping the last four; 17-bit intermediate avoids overflow.
  assign num_digit = 16'(((17'(num_q) % 17'd1000) * 17'd10) + {13'd0, code});

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_meta  <= 4'hF;
      rows_sync  <= 4'hF;
      div_cnt    <= '0;
      col_idx    <= 2'd0;
      frame      <= 16'd0;
      prev_frame <= 16'd0;
      match_cnt  <= '0;
    end else begin
      rows_meta <= kp.rows;
      rows_sync <= rows_meta;
      if (sample) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        frame   <= frame_new;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (frame_done) begin
        prev_frame <= frame_new;
        match_cnt  <= match_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    if (stable) begin
      case (state)
        RELEASED: begin
          if (single_key) begin
            fire       = 1'b1;
            state_next = HELD;
          end
        end
        HELD: begin
          if (frame_new == 16'd0) begin
            state_next = RELEASED;
          end
        end
        default: state_next = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q   <= 16'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= fire;
      if (fire) begin
        code_q <= code;
        if (code <= KEY_9) begin
          num_q <= num_digit;
        end else if (code == KEY_C) begin
          num_q <= 16'd0;
        end else if (code == KEY_B) begin
          num_q <= num_q / 16'd10;
        end
      end
    end
  end

  assign kp.cols      = ~(4'b0001 << col_idx);
  assign kp.num       = num_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// tb_keypad_entry : directed vector bench for keypad_entry (SCAN_DIV=4, DEBOUNCE=2)
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int NVEC     = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = 16'd0;
  logic [3:0]  rows_drv;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  keypad_if kif ();

  keypad_entry #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kif.master)
  );

  // Passive switch matrix: a pressed key shorts its row to the low column.
  always_comb begin
    rows_drv = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!kif.cols[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (pressed[4*c + r]) rows_drv[r] = 1'b0;
        end
      end
    end
  end
  assign kif.rows = rows_drv;

  typedef struct {
    logic [15:0] keys;
    bit          evt;
    logic [3:0]  code;
    logic [15:0] num;
    bit          rel;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [15:0] km(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (4*c + r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_press(input logic [15:0] keys, input bit evt, input logic [3:0] code,
                             input logic [15:0] num, input bit rel, input string name);
    int          pulses;
    int          first;
    logic [3:0]  cap_code;
    logic [15:0] cap_num;
    pulses   = 0;
    first    = -1;
    cap_code = 4'd0;
    cap_num  = 16'd0;
    pressed  = keys;
    for (int t = 1; t <= 70; t++) begin
      @(negedge clk);
      if (kif.key_valid) begin
        pulses++;
        if (first < 0) begin
          first    = t;
          cap_code = kif.key_code;
          cap_num  = kif.num;
        end
      end
    end
    check({name, " pulses"}, pulses, evt ? 1 : 0);
    if (evt) begin
      check({name, " code"}, cap_code, code);
      check({name, " num"}, cap_num, num);
      check({name, " latency<=51"}, (first >= 1 && first <= 51) ? 1 : 0, 1);
    end
    check({name, " num held"}, kif.num, num);
    if (rel) begin
      pressed = 16'd0;
      pulses  = 0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        if (kif.key_valid) pulses++;
      end
      check({name, " release pulses"}, pulses, 0);
    end
  endtask

  // Return at the first negedge of a column-0 period (divider at 0).
  task automatic wait_frame_start(input string name);
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    prev  = kif.cols;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (kif.cols == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = kif.cols;
    end
    check({name, " frame sync"}, found, 1);
  endtask

  initial begin
    int         pulses;
    int         first;
    logic [3:0] exp_cols;

    //               keys           evt  code   num        rel
    vecs[0]  = '{km(1,1),              1, 4'h5, 16'd5,    1};
    vecs[1]  = '{km(2,3),              1, 4'hC, 16'd0,    1};
    vecs[2]  = '{km(0,0),              1, 4'h1, 16'd1,    1};
    vecs[3]  = '{km(0,1),              1, 4'h2, 16'd12,   1};
    vecs[4]  = '{km(0,2),              1, 4'h3, 16'd123,  1};
    vecs[5]  = '{km(1,0),              1, 4'h4, 16'd1234, 1};
    vecs[6]  = '{km(1,1),              1, 4'h5, 16'd2345, 1};
    vecs[7]  = '{km(1,3),              1, 4'hB, 16'd234,  1};
    vecs[8]  = '{km(2,3),              1, 4'hC, 16'd0,    1};
    vecs[9]  = '{km(0,3),              1, 4'hA, 16'd0,    1};
    vecs[10] = '{km(2,1),              1, 4'h8, 16'd8,    1};
    vecs[11] = '{km(3,3),              1, 4'hD, 16'd8,    1};
    vecs[12] = '{km(3,0),              1, 4'h0, 16'd80,   1};
    vecs[13] = '{km(0,0) | km(0,1),    0, 4'h0, 16'd80,   0};
    vecs[14] = '{km(0,0),              1, 4'h1, 16'd801,  0};
    vecs[15] = '{km(0,0) | km(0,2),    0, 4'h0, 16'd801,  0};
    vecs[16] = '{16'd0,                0, 4'h0, 16'd801,  1};
    vecs[17] = '{km(2,2),              1, 4'h9, 16'd8019, 1};
    vecs[18] = '{km(1,2),              1, 4'h6, 16'd196,  1};
    vecs[19] = '{km(1,3),              1, 4'hB, 16'd19,   1};
    vecs[20] = '{km(3,1),              1, 4'hF, 16'd19,   1};
    vecs[21] = '{km(3,2),              1, 4'hE, 16'd19,   1};

    // Reset values and free-running column scan
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset cols", kif.cols, 4'b1110);
    check("reset num", kif.num, 0);
    check("reset key_code", kif.key_code, 0);
    check("reset key_valid", kif.key_valid, 0);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      exp_cols = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      check($sformatf("scan cols[%0d]", i), kif.cols, exp_cols);
      if (kif.key_valid) pulses++;
      @(negedge clk);
    end
    check("idle pulses", pulses, 0);
    check("idle num", kif.num, 0);

    for (int i = 0; i < NVEC; i++) begin
      apply_press(vecs[i].keys, vecs[i].evt, vecs[i].code, vecs[i].num,
                  vecs[i].rel, $sformatf("vec%0d", i));
    end

    // Bouncing "7": toggle every 5 cycles, then hold
    apply_press(km(2,3), 1, 4'hC, 16'd0, 1, "bounce clear");
    wait_frame_start("bounce");
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      pressed = (((t / 5) % 2) == 0) ? km(2,0) : 16'd0;
      @(negedge clk);
      if (kif.key_valid) pulses++;
    end
    check("bounce toggling pulses", pulses, 0);
    apply_press(km(2,0), 1, 4'h7, 16'd7, 1, "bounce settled");

    // Reset while "9" is mid-debounce
    wait_frame_start("rstmid");
    pressed = km(2,2);
    pulses  = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (kif.key_valid) pulses++;
    end
    check("rstmid pre-reset pulses", pulses, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rstmid num after reset", kif.num, 0);
    check("rstmid key_valid after reset", kif.key_valid, 0);
    pulses = 0;
    first  = -1;
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      if (kif.key_valid) begin
        pulses++;
        if (first < 0) begin
          first = t;
          check("rstmid code", kif.key_code, 4'h9);
          check("rstmid num", kif.num, 16'd9);
        end
      end
    end
    check("rstmid pulses", pulses, 1);
    check("rstmid not before 32", (first >= 32) ? 1 : 0, 1);
    pressed = 16'd0;
    repeat (60) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 active-low matrix keypad, debounces it, and assembles decimal keystrokes into a 16-bit value in the range 0..9999. This value drives the `num` input of the 4-digit seven-segment display driver. It is the input-side counterpart of that display path: it strobes columns and reads rows, where the display strobes anodes and drives cathodes. It is the board's manual entry point for test values.

## Interface

**Parameters**
- `SCAN_DIV`, default 25000: clock cycles each column is held low. Must be ≥ 2.
- `DEBOUNCE`, default 4: number of consecutive identical complete scan frames required to accept a key pattern. Must be ≥ 1.

**Ports**
- `clk` input, 1: system clock.
- `rst` input, 1: synchronous, active-high reset.
- `cols` output, 4: column strobes, active low, exactly one bit low at any time.
- `rows` input, 4: row returns, active low, externally pulled up.
- `num` output, 16: entered value, binary, 0..9999.
- `key_code` output, 4: code of the last accepted key.
- `key_valid` output, 1: one-cycle pulse per accepted key press.

## Operation

**Key map** (row r, column c → code; `cols[c]` low and `rows[r]` low means pressed):
- r0: 1, 2, 3, A
- r1: 4, 5, 6, B
- r2: 7, 8, 9, C
- r3: 0, F, E, D

**Scan**
- Column index c steps 0→1→2→3→0. Each column is held for `SCAN_DIV` cycles, and `cols = ~(1<<c)`.
- `rows` are sampled on the last cycle of each column period, giving 4 bits per column. Those bits go into a 16-bit frame register, with bit 4c+r set for a pressed key.
- A frame completes on the sample of column 3.

**Debounce**
- At frame completion, compare the new frame against the previous frame.
  - Equal: the match counter increments, saturating at `DEBOUNCE`.
  - Different: the match counter is set to 1.
- The pattern is *stable* when the counter reaches `DEBOUNCE`.
- `rows` passes through a 2-flop synchronizer before sampling.

**FSM**
- RELEASED (reset state):
  - Stable pattern with exactly one bit set → emit event, go to HELD.
  - Zero bits or ≥ 2 bits → stay, no event.
- HELD: stable all-zero pattern → RELEASED. Any other pattern → stay; a roll-over to another key produces no event.

**Event**
- `key_code` = mapped code and `key_valid` = 1 for one cycle.
- `num` updates in the same cycle:
  - Digit d (0–9): `num <= (num % 1000) * 10 + d`, so the last four digits are kept.
  - C: `num <= 0`.
  - B (backspace): `num <= num / 10`.
  - A, D, E, F: `num` unchanged, event still reported.
- Intermediate arithmetic is at least 17 bits wide. `num` never exceeds 9999.

## Timing

- **Reset values:** `cols = 4'b1110` (c = 0), `num = 0`, `key_code = 0`, `key_valid = 0`. Frame and previous-frame registers are 0, match counter is 0, divider is 0, FSM is RELEASED.
- **Reset mid-scan or mid-debounce:** everything above is restored. A key held through reset must reach stability again before it generates an event.
- **Frame length:** 4·`SCAN_DIV` cycles.
- **Event timing:** `key_valid` asserts in the cycle after the frame completion at which stability is reached.
- **Latency:** a clean press applied at any point produces an event within (`DEBOUNCE` + 1) frames + 3 cycles (synchronizer plus register).
- **Register timing:** `num` and `key_code` are registered. Both show their new values in the same cycle `key_valid` is high, and hold until the next event.
- **Event rate:** at most one event per press/release cycle. Holding a key never auto-repeats.

## Test plan

Run with `SCAN_DIV=4` and `DEBOUNCE=2` (frame = 16 cycles).

1. **Reset:** hold `rst` for 3 cycles with `rows = 4'hF`.
   - `cols` cycles 1110, 1101, 1011, 0111 every 4 cycles.
   - `num = 0` and `key_valid` never asserts.
2. **Single key:** press key "5" (drive `rows[1]` low whenever `cols[1]` is low) and hold it.
   - Exactly one `key_valid` pulse within 51 cycles, with `key_code = 5` and `num = 5`.
   - No further pulses while the key is held.
3. **Entry sequence:** enter 1, 2, 3, 4, 5, each with a clean release between.
   - After the 4th event, `num = 1234`. After the 5th, `num = 2345`.
   - Then press B → `num = 234`. Then press C → `num = 0`.
4. **Bounce:** toggle key "7" every 5 cycles for 40 cycles, then hold it steady.
   - No event during the toggling.
   - Exactly one event with `num = 7` after the pattern has been stable for 2 frames.
5. **Multi-key:**
   - Press 1 and 2 together → no event.
   - Release 2 while keeping 1 → event with `key_code = 1`.
   - Press 3 while 1 is still held → no event until all keys are released.
6. **Reset mid-debounce:** press "9", assert `rst` 20 cycles after the press, release `rst` with "9" still held.
   - `num` reads 0 after reset.
   - One event with `num = 9` arrives no earlier than 32 cycles after reset is released.
